// File: rtl/port_access_sequencer_pkg.sv
// Shared constants and helpers for the port access sequencer: interface
// register codes, port ids, FSM state encoding and bus address formatting.
package port_access_sequencer_pkg;

  localparam int DATA_WIDTH = 8;

  // Interface register codes; addr_bus[7:4] selects a read source,
  // addr_bus[3:0] a write destination.
  localparam logic [3:0] REG_NONE = 4'h0;
  localparam logic [3:0] PA       = 4'h1;  // port select register
  localparam logic [3:0] PD       = 4'h2;  // port data register

  // Port ids known to the interface.
  localparam logic [DATA_WIDTH-1:0] PORT0 = 8'h00;  // input-only
  localparam logic [DATA_WIDTH-1:0] PORT1 = 8'h01;
  localparam logic [DATA_WIDTH-1:0] PORT2 = 8'h02;

  typedef enum logic [1:0] {
    PAS_IDLE = 2'd0,
    PAS_SEL  = 2'd1,
    PAS_ACC  = 2'd2,
    PAS_DONE = 2'd3
  } pas_state_e;

  // Address for the PA write cycle.
  function automatic logic [7:0] sel_addr();
    return {REG_NONE, PA};
  endfunction

  // Address for the PD access cycle: PD as destination on writes,
  // as source on reads; the other nibble is always REG_NONE.
  function automatic logic [7:0] acc_addr(input logic we);
    return we ? {REG_NONE, PD} : {PD, REG_NONE};
  endfunction

endpackage

// File: rtl/port_access_sequencer_if.sv
// Request/ack handshake plus I/O port bus signals of the sequencer.
// master: the sequencer itself; slave: requesters and the port interface.
interface port_access_sequencer_if
  import port_access_sequencer_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ*DATA_WIDTH-1:0] req_port;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        busy;
  logic [7:0]                  addr_bus;
  logic [DATA_WIDTH-1:0]       data_bus_o;
  logic [DATA_WIDTH-1:0]       data_bus_i;

  modport master (
    input  req, req_we, req_port, req_wdata, data_bus_i,
    output ack, rdata, busy, addr_bus, data_bus_o
  );

  modport slave (
    output req, req_we, req_port, req_wdata, data_bus_i,
    input  ack, rdata, busy, addr_bus, data_bus_o
  );

endinterface

// File: rtl/port_access_sequencer_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward, wrapping modulo N, and
// returns the first requesting index as one-hot gnt and binary idx.
module port_access_sequencer_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          grant_en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Pick the first requester after the last winner.
  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output gets a default before the search loop, so no path
    // leaves gnt/idx unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (grant_en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/port_access_sequencer.sv
// Sole bus master of the I/O port interface. Arbitrates requesters, then
// runs PA (port select, skipped on a select-cache hit), PD (data access)
// and a one-cycle ack. All bus outputs are registered.
module port_access_sequencer
  import port_access_sequencer_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter bit SEL_CACHE = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  port_access_sequencer_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  pas_state_e            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         lat_idx;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_port;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] sel_port;
  logic                  sel_valid;

  logic [N_REQ-1:0]      gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  g_we;
  logic [DATA_WIDTH-1:0] g_port;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  sel_hit;

  port_access_sequencer_rr_arbiter #(.N(N_REQ)) u_arb (
    .req      (bus.req),
    .ptr      (rr_ptr),
    .grant_en (state == PAS_IDLE),
    .gnt      (gnt),
    .idx      (gnt_idx)
  );

  // Fields of the requester the arbiter is offering this cycle.
  assign g_we    = bus.req_we[gnt_idx];
  assign g_port  = bus.req_port[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign g_wdata = bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_hit = SEL_CACHE && sel_valid && (g_port == sel_port);

  // Transaction FSM with request latch, select cache and registered bus drivers.
  always_ff @(posedge clk) begin
    // NOTE: everything here is control state, so all of it is reset; the
    // cache valid bit in particular must clear so an aborted select is
    // never trusted afterwards.
    if (!rst_n) begin
      state          <= PAS_IDLE;
      rr_ptr         <= IW'(N_REQ - 1);
      lat_idx        <= '0;
      lat_we         <= 1'b0;
      lat_port       <= '0;
      lat_wdata      <= '0;
      sel_port       <= '0;
      sel_valid      <= 1'b0;
      bus.ack        <= '0;
      bus.rdata      <= '0;
      bus.busy       <= 1'b0;
      bus.addr_bus   <= {REG_NONE, REG_NONE};
      bus.data_bus_o <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of state and the latched fields.
      case (state)
        PAS_IDLE: begin
          bus.ack <= '0;
          if (|gnt) begin
            lat_idx   <= gnt_idx;
            lat_we    <= g_we;
            lat_port  <= g_port;
            lat_wdata <= g_wdata;
            rr_ptr    <= gnt_idx;
            bus.busy  <= 1'b1;
            if (sel_hit) begin
              state          <= PAS_ACC;
              bus.addr_bus   <= acc_addr(g_we);
              bus.data_bus_o <= g_we ? g_wdata : '0;
            end else begin
              state          <= PAS_SEL;
              bus.addr_bus   <= sel_addr();
              bus.data_bus_o <= g_port;
            end
          end
        end
        PAS_SEL: begin
          sel_port       <= lat_port;
          sel_valid      <= 1'b1;
          state          <= PAS_ACC;
          bus.addr_bus   <= acc_addr(lat_we);
          bus.data_bus_o <= lat_we ? lat_wdata : '0;
        end
        PAS_ACC: begin
          bus.rdata      <= lat_we ? '0 : bus.data_bus_i;
          bus.ack        <= N_REQ'(1) << lat_idx;
          state          <= PAS_DONE;
          bus.addr_bus   <= {REG_NONE, REG_NONE};
          bus.data_bus_o <= '0;
        end
        default: begin  // PAS_DONE
          bus.ack  <= '0;
          bus.busy <= 1'b0;
          state    <= PAS_IDLE;
        end
      endcase
    end
  end

endmodule
